// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the UART TX FIFO write port.
// The requester/FIFO side uses modport master, the arbiter uses modport slave.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_full;
  logic [7:0]        w_data;
  logic              wr_uart;
  logic              busy;
  logic [GW-1:0]     grant_id;
  logic              truncated;
  logic              abort;

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, w_data, wr_uart, busy, grant_id, truncated, abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, w_data, wr_uart, busy, grant_id, truncated, abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte-stream requesters.
// A grant is held for a whole message, capped at MAX_LEN bytes and revoked after TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic [GW-1:0] LAST_ID   = GW'(NREQ - 1);
  localparam logic [CW-1:0] LEN_LIMIT = CW'(MAX_LEN - 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT - 1);

  logic [0:0]    state_r;
  logic [GW-1:0] grant_id_r;
  logic [CW-1:0] byte_cnt_r;
  logic [SW-1:0] stall_cnt_r;
  logic [7:0]    w_data_r;
  logic          wr_uart_r;
  logic          truncated_r;
  logic          abort_r;

  logic [0:0]      state_s;
  logic [GW-1:0]   grant_id_s;
  logic [CW-1:0]   byte_cnt_s;
  logic [SW-1:0]   stall_cnt_s;
  logic [7:0]      w_data_s;
  logic            wr_uart_s;
  logic            truncated_s;
  logic            abort_s;
  logic [NREQ-1:0] ready_s;
  logic [GW-1:0]   winner_s;
  logic            any_req_s;
  logic            g_valid_s;
  logic            g_last_s;
  logic [7:0]      g_data_s;
  logic            accept_s;

  // First asserted request searched cyclically from the slot after the previous grant.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] valid, input logic [GW-1:0] prev);
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          found;
    pick  = prev;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx   = GW'((int'(prev) + i) % NREQ);
      pick  = found ? pick : (valid[idx] ? idx : pick);
      found = found | valid[idx];
    end
    return pick;
  endfunction

  assign any_req_s = |bus.req_valid;
  assign winner_s  = rr_pick(bus.req_valid, grant_id_r);
  assign g_valid_s = bus.req_valid[grant_id_r];
  assign g_last_s  = bus.req_last[grant_id_r];
  assign g_data_s  = bus.req_data[{grant_id_r, 3'b000} +: 8];
  assign accept_s  = g_valid_s & ready_s[grant_id_r];

  // Only the granted lane may be ready; ~wr_uart_r covers the one-cycle lag of tx_full.
  always_comb begin
    ready_s = '0;
    if ((state_r == XFER) && !bus.tx_full && !wr_uart_r) begin
      ready_s[grant_id_r] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Next-state logic: arbitration in IDLE, byte acceptance, length cap and stall timeout in XFER.
  always_comb begin
    state_s     = state_r;
    grant_id_s  = grant_id_r;
    byte_cnt_s  = byte_cnt_r;
    stall_cnt_s = stall_cnt_r;
    w_data_s    = w_data_r;
    wr_uart_s   = 1'b0;
    truncated_s = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_id_s  = winner_s;
          state_s     = XFER;
          byte_cnt_s  = '0;
          stall_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        if (accept_s) begin
          wr_uart_s   = 1'b1;
          w_data_s    = g_data_s;
          byte_cnt_s  = byte_cnt_r + CW'(1);
          stall_cnt_s = '0;
          if (g_last_s) begin
            state_s = IDLE;
          end else if (byte_cnt_r == LEN_LIMIT) begin
            state_s     = IDLE;
            truncated_s = 1'b1;
          end else begin
            state_s = XFER;
          end
        end else if (g_valid_s) begin
          // Waiting on tx_full while still valid is not a stall.
          stall_cnt_s = '0;
        end else if (stall_cnt_r == STALL_LIM) begin
          stall_cnt_s = '0;
          abort_s     = 1'b1;
          state_s     = IDLE;
        end else begin
          stall_cnt_s = stall_cnt_r + SW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      grant_id_r  <= LAST_ID;
      byte_cnt_r  <= '0;
      stall_cnt_r <= '0;
      w_data_r    <= 8'h00;
      wr_uart_r   <= 1'b0;
      truncated_r <= 1'b0;
      abort_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      grant_id_r  <= grant_id_s;
      byte_cnt_r  <= byte_cnt_s;
      stall_cnt_r <= stall_cnt_s;
      w_data_r    <= w_data_s;
      wr_uart_r   <= wr_uart_s;
      truncated_r <= truncated_s;
      abort_r     <= abort_s;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.w_data    = w_data_r;
  assign bus.wr_uart   = wr_uart_r;
  assign bus.busy      = (state_r == XFER);
  assign bus.grant_id  = grant_id_r;
  assign bus.truncated = truncated_r;
  assign bus.abort     = abort_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester models replay byte messages, a monitor logs writes.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 1024;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_LEN(16), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Requester model: message i is msg_len[i] bytes msg_base[i]+pos; mode 0 last on final byte,
  // mode 1 last on every byte, mode 2 never last.
  int         acc_cnt  [NREQ];
  int         msg_st   [NREQ];
  int         msg_len  [NREQ];
  int         msg_mode [NREQ];
  logic [7:0] msg_base [NREQ];

  logic [7:0] wdat [$];
  logic [1:0] wgid [$];
  int         trunc_cnt;
  int         abort_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pos_of(input int i);
    return acc_cnt[i] - msg_st[i];
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       <= (pos_of(i) < msg_len[i]);
      bus.req_data[8*i +: 8] <= msg_base[i] + 8'(pos_of(i));
      bus.req_last[i]        <= (msg_mode[i] == 1) ||
                                ((msg_mode[i] == 0) && (pos_of(i) == msg_len[i] - 1));
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
    end
  end

  always @(negedge clk) begin
    if (bus.wr_uart === 1'b1) begin
      wdat.push_back(bus.w_data);
      wgid.push_back(bus.grant_id);
    end
    if (bus.truncated === 1'b1) trunc_cnt <= trunc_cnt + 1;
    if (bus.abort === 1'b1) abort_cnt <= abort_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int i, input int len, input logic [7:0] base, input int mode);
    msg_st[i]   = acc_cnt[i];
    msg_len[i]  = len;
    msg_base[i] = base;
    msg_mode[i] = mode;
  endtask

  task automatic wait_writes(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound && !ok; n++) begin
      tick();
      ok = (wdat.size() >= target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tx_full = 1'b0;
    for (int i = 0; i < NREQ; i++) msg_len[i] = 0;
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    total++; if (bus.wr_uart !== 1'b0) begin bad++; $display("FAIL reset_wr_uart: got %0b want 0", bus.wr_uart); end
    total++; if (bus.w_data !== 8'h00) begin bad++; $display("FAIL reset_w_data: got %0h want 00", bus.w_data); end
    total++; if (bus.grant_id !== 2'd3) begin bad++; $display("FAIL reset_grant_id: got %0d want 3", bus.grant_id); end
    total++; if (bus.truncated !== 1'b0) begin bad++; $display("FAIL reset_truncated: got %0b want 0", bus.truncated); end
    total++; if (bus.abort !== 1'b0) begin bad++; $display("FAIL reset_abort: got %0b want 0", bus.abort); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_msg();
    int b0;
    int t0;
    bit ok;
    logic [7:0] exp_d;
    test_reset();
    b0 = wdat.size();
    t0 = trunc_cnt;
    load(1, 3, 8'h41, 0);
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL arb_cycle_busy: got %0b want 0", bus.busy); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL arb_cycle_ready: got %b want 0000", bus.req_ready); end
    tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL grant_busy: got %0b want 1", bus.busy); end
    total++; if (bus.grant_id !== 2'd1) begin bad++; $display("FAIL grant_id_1: got %0d want 1", bus.grant_id); end
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL grant_ready: got %b want 0010", bus.req_ready); end
    wait_writes(b0 + 3, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got %0d writes want 3", wdat.size() - b0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %0b want 0", bus.busy); end
    for (int k = 0; k < 3; k++) begin
      exp_d = 8'h41 + 8'(k);
      total++; if (wdat[b0+k] !== exp_d) begin bad++; $display("FAIL single_data%0d: got %0h want %0h", k, wdat[b0+k], exp_d); end
      total++; if (wgid[b0+k] !== 2'd1) begin bad++; $display("FAIL single_gid%0d: got %0d want 1", k, wgid[b0+k]); end
    end
    total++; if (trunc_cnt !== t0) begin bad++; $display("FAIL single_truncated: got %0d pulses want 0", trunc_cnt - t0); end
  endtask

  task automatic test_back_to_back();
    int b0;
    bit ok;
    logic [1:0] eg [5];
    logic [7:0] ed [5];
    eg = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ed = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1};
    test_reset();
    b0 = wdat.size();
    load(0, 2, 8'hA0, 1);
    load(1, 1, 8'hB0, 1);
    load(2, 1, 8'hC0, 1);
    load(3, 1, 8'hD0, 1);
    wait_writes(b0 + 5, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_timeout: got %0d writes want 5", wdat.size() - b0); end
    for (int k = 0; k < 5; k++) begin
      total++; if (wgid[b0+k] !== eg[k]) begin bad++; $display("FAIL rr_gid%0d: got %0d want %0d", k, wgid[b0+k], eg[k]); end
      total++; if (wdat[b0+k] !== ed[k]) begin bad++; $display("FAIL rr_data%0d: got %0h want %0h", k, wdat[b0+k], ed[k]); end
    end
  endtask

  task automatic test_tx_full();
    int b0;
    int a0;
    bit ok;
    logic [7:0] exp_d;
    test_reset();
    b0 = wdat.size();
    a0 = abort_cnt;
    load(1, 6, 8'h60, 0);
    wait_writes(b0 + 2, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_pre_timeout: got %0d writes want 2", wdat.size() - b0); end
    bus.tx_full = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL full_ready%0d: got %b want 0000", n, bus.req_ready); end
      total++; if (bus.wr_uart !== 1'b0) begin bad++; $display("FAIL full_wr%0d: got %0b want 0", n, bus.wr_uart); end
    end
    total++; if (abort_cnt !== a0) begin bad++; $display("FAIL full_abort: got %0d pulses want 0", abort_cnt - a0); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL full_busy: got %0b want 1", bus.busy); end
    bus.tx_full = 1'b0;
    wait_writes(b0 + 6, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_resume: got %0d writes want 6", wdat.size() - b0); end
    for (int k = 0; k < 6; k++) begin
      exp_d = 8'h60 + 8'(k);
      total++; if (wdat[b0+k] !== exp_d) begin bad++; $display("FAIL full_data%0d: got %0h want %0h", k, wdat[b0+k], exp_d); end
    end
  endtask

  task automatic test_truncate();
    int b0;
    int t0;
    int a0;
    bit ok;
    logic [7:0] exp_d;
    test_reset();
    b0 = wdat.size();
    t0 = trunc_cnt;
    a0 = abort_cnt;
    load(2, 20, 8'h00, 2);
    load(3, 1, 8'hE0, 1);
    wait_writes(b0 + 17, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL trunc_timeout: got %0d writes want 17", wdat.size() - b0); end
    for (int k = 0; k < 16; k++) begin
      exp_d = 8'(k);
      total++; if (wdat[b0+k] !== exp_d) begin bad++; $display("FAIL trunc_data%0d: got %0h want %0h", k, wdat[b0+k], exp_d); end
      total++; if (wgid[b0+k] !== 2'd2) begin bad++; $display("FAIL trunc_gid%0d: got %0d want 2", k, wgid[b0+k]); end
    end
    total++; if (wgid[b0+16] !== 2'd3) begin bad++; $display("FAIL trunc_next_gid: got %0d want 3", wgid[b0+16]); end
    total++; if (wdat[b0+16] !== 8'hE0) begin bad++; $display("FAIL trunc_next_data: got %0h want e0", wdat[b0+16]); end
    total++; if (trunc_cnt - t0 !== 1) begin bad++; $display("FAIL trunc_pulses: got %0d want 1", trunc_cnt - t0); end
    total++; if (abort_cnt !== a0) begin bad++; $display("FAIL trunc_abort: got %0d pulses want 0", abort_cnt - a0); end
  endtask

  task automatic test_timeout();
    int b0;
    int a0;
    int n;
    bit ok;
    bit seen;
    test_reset();
    b0 = wdat.size();
    a0 = abort_cnt;
    load(0, 1, 8'h55, 2);
    load(1, 1, 8'h66, 1);
    wait_writes(b0 + 1, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_first_write: got %0d writes want 1", wdat.size() - b0); end
    seen = 1'b0;
    n = 0;
    while (!seen && n < TIMEOUT + 50) begin
      tick();
      n++;
      seen = (abort_cnt != a0);
    end
    total++; if (n !== TIMEOUT) begin bad++; $display("FAIL stall_abort_delay: got %0d cycles want %0d", n, TIMEOUT); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stall_busy: got %0b want 0", bus.busy); end
    total++; if (wdat.size() !== b0 + 1) begin bad++; $display("FAIL stall_extra_write: got %0d writes want 1", wdat.size() - b0); end
    tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL stall_regrant_busy: got %0b want 1", bus.busy); end
    total++; if (bus.grant_id !== 2'd1) begin bad++; $display("FAIL stall_regrant_gid: got %0d want 1", bus.grant_id); end
    wait_writes(b0 + 2, 20, ok);
    total++; if (wdat[b0+1] !== 8'h66) begin bad++; $display("FAIL stall_next_data: got %0h want 66", wdat[b0+1]); end
    total++; if (abort_cnt - a0 !== 1) begin bad++; $display("FAIL stall_abort_pulses: got %0d want 1", abort_cnt - a0); end
  endtask

  task automatic test_reset_mid();
    int b0;
    bit ok;
    test_reset();
    b0 = wdat.size();
    load(0, 4, 8'h70, 0);
    wait_writes(b0 + 1, 20, ok);
    total++; if (bus.wr_uart !== 1'b1) begin bad++; $display("FAIL mid_pre_wr: got %0b want 1", bus.wr_uart); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.wr_uart !== 1'b0) begin bad++; $display("FAIL mid_wr_uart: got %0b want 0", bus.wr_uart); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b want 0", bus.busy); end
    total++; if (bus.grant_id !== 2'd3) begin bad++; $display("FAIL mid_grant_id: got %0d want 3", bus.grant_id); end
    total++; if (bus.w_data !== 8'h00) begin bad++; $display("FAIL mid_w_data: got %0h want 00", bus.w_data); end
    for (int i = 0; i < NREQ; i++) msg_len[i] = 0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.tx_full = 1'b0;
    test_reset();
    test_single_msg();
    test_back_to_back();
    test_tx_full();
    test_truncate();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
